// File: rtl/coord_link_pkg.sv
// Shared types, frame geometry and frame packing for the GPIO coordinate link.
// COORD_LINK_PARITY_EN appends an even-parity bit to every frame.
package coord_link_pkg;

    localparam int COORD_W = 9;

`ifdef COORD_LINK_PARITY_EN
    localparam int FRAME_BITS = 2 * COORD_W + 2;
`else
    localparam int FRAME_BITS = 2 * COORD_W + 1;
`endif

    localparam int BIT_CNT_W = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } link_state_t;

    // Transmit order is MSB first: x[8..0], y[8..0], shot, then optional parity.
    function automatic logic [FRAME_BITS-1:0] frame_pack(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input logic               shot
    );
        logic [2*COORD_W:0] payload;
        payload = {x, y, shot};
`ifdef COORD_LINK_PARITY_EN
        return {payload, ^payload};
`else
        return payload;
`endif
    endfunction

endpackage

// File: rtl/coord_link_tx_bit_timer.sv
// Per-bit divider for the coordinate link: counts 0..CLK_DIV-1 and produces the
// registered link-clock phase plus an end-of-bit tick.
module link_bit_timer #(
    parameter int CLK_DIV = 50
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic clear,
    input  logic run,
    output logic half,
    output logic bit_end
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] HALF_PT  = DIV_W'(CLK_DIV / 2);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_nxt;

    always_comb begin
        div_nxt = div_q + 1'b1;
        if (clear || !run || (div_q == DIV_LAST)) begin
            div_nxt = '0;
        end
    end

    // half is computed from the next divider value so gpio_clk is a plain flop
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_q <= '0;
            half  <= 1'b0;
        end else begin
            div_q <= div_nxt;
            half  <= run && (div_nxt >= HALF_PT);
        end
    end

    assign bit_end = (div_q == DIV_LAST);

endmodule

// File: rtl/coord_link_tx.sv
// Serial transmitter for the GPIO coordinate link (link clock, data, frame enable).
// Build option: define COORD_LINK_PARITY_EN for a 20-bit frame with even parity.
//
//   state | meaning
//   ------+--------------------------------------------------
//   IDLE  | ready for a new coordinate, link outputs low
//   SHIFT | frame on the wire, one bit per CLK_DIV cycles
//   GAP   | forced quiet time of GAP_BITS bit periods
module coord_link_tx
    import coord_link_pkg::*;
#(
    parameter int CLK_DIV  = 50,
    parameter int GAP_BITS = 4
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [COORD_W-1:0] coord_x,
    input  logic [COORD_W-1:0] coord_y,
    input  logic               shot,
    input  logic               coord_valid,
    output logic               coord_ready,
    output logic               gpio_clk,
    output logic               gpio_data,
    output logic               gpio_frame,
    output logic               busy
);

    localparam int GAP_CYC = GAP_BITS * CLK_DIV;
    localparam int GAP_W   = $clog2(GAP_CYC);
    localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

    link_state_t state_q;
    link_state_t state_nxt;

    logic [FRAME_BITS-1:0] sreg_q;
    logic [BIT_CNT_W-1:0]  bit_cnt_q;
    logic [GAP_W-1:0]      gap_cnt_q;
    logic                  accept;
    logic                  bit_end;
    logic                  shift_tick;
    logic                  timer_run;

    assign accept     = coord_valid && (state_q == IDLE);
    assign shift_tick = (state_q == SHIFT) && bit_end;
    assign timer_run  = (state_nxt == SHIFT);

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (coord_valid) state_nxt = SHIFT;
            SHIFT:   if (shift_tick && (bit_cnt_q == LAST_BIT)) state_nxt = GAP;
            GAP:     if (gap_cnt_q == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    link_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clear   (accept),
        .run     (timer_run),
        .half    (gpio_clk),
        .bit_end (bit_end)
    );

    // Shifting in zeros leaves the register empty after the last bit, so the
    // data line is naturally low in GAP and IDLE.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sreg_q    <= '0;
            bit_cnt_q <= '0;
        end else if (accept) begin
            sreg_q    <= frame_pack(coord_x, coord_y, shot);
            bit_cnt_q <= '0;
        end else if (shift_tick) begin
            sreg_q    <= {sreg_q[FRAME_BITS-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            gap_cnt_q <= '0;
        end else if ((state_q == SHIFT) && (state_nxt == GAP)) begin
            gap_cnt_q <= GAP_LAST;
        end else if ((state_q == GAP) && (gap_cnt_q != '0)) begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            gpio_frame <= 1'b0;
        end else begin
            gpio_frame <= (state_nxt == SHIFT);
        end
    end

    assign gpio_data   = sreg_q[FRAME_BITS-1];
    assign coord_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);

endmodule
